// File: rtl/icache_pkg.sv
// Shared definitions for the n-way instruction cache: controller states,
// Wishbone data width and address-field width helpers.
package icache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    localparam int BUS_W     = 64;
    localparam int BUS_BYTES = BUS_W / 8;

    function automatic int off_w(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int sets, input int line_bytes);
        return addr_w - off_w(line_bytes) - idx_w(sets);
    endfunction

    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/icache_if.sv
// Wishbone pipelined bus between the instruction cache (master) and memory.
interface icache_if #(
    parameter int ADDR_W = 64
);
    logic [ADDR_W-1:0]           o_wb_adr;
    logic [icache_pkg::BUS_W-1:0] i_wb_dat;
    logic [icache_pkg::BUS_W-1:0] o_wb_dat;
    logic                        o_wb_we;
    logic [7:0]                  o_wb_sel;
    logic                        o_wb_stb;
    logic                        i_wb_ack;
    logic                        o_wb_cyc;
    logic                        i_wb_stall;
    logic                        i_wb_rty;
    logic                        o_wb_lock;

    modport master (
        output o_wb_adr, o_wb_dat, o_wb_we, o_wb_sel, o_wb_stb, o_wb_cyc, o_wb_lock,
        input  i_wb_dat, i_wb_ack, i_wb_stall, i_wb_rty
    );

    modport slave (
        input  o_wb_adr, o_wb_dat, o_wb_we, o_wb_sel, o_wb_stb, o_wb_cyc, o_wb_lock,
        output i_wb_dat, i_wb_ack, i_wb_stall, i_wb_rty
    );
endinterface

// File: rtl/icache_victim_sel.sv
// Replacement choice: lowest-index invalid way, otherwise the set's round-robin way.
module icache_victim_sel
    import icache_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int PTR_W = way_w(WAYS)
) (
    input  logic [WAYS-1:0]  valid,
    input  logic [PTR_W-1:0] ptr,
    output logic [WAYS-1:0]  victim_oh
);

    logic found;

    always_comb begin
        victim_oh = '0;
        found     = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !valid[w]) begin
                victim_oh[w] = 1'b1;
                found        = 1'b1;
            end
        end
        if (!found) begin
            victim_oh[ptr] = 1'b1;
        end
    end

endmodule

// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with Wishbone line refill and full flush.
// Define ICACHE_EARLY_FWD_EN to forward the critical word straight off the bus during refill.
module icache_nway
    import icache_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_BYTES = 64
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    icache_if.master          wb,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       o_data,
    output logic              o_data_ready,
    input  logic              i_invalidate,
    output logic              o_invalidating
);

    localparam int BEATS  = LINE_BYTES / BUS_BYTES;
    localparam int OFF_W  = off_w(LINE_BYTES);
    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = tag_w(ADDR_W, SETS, LINE_BYTES);
    localparam int BEAT_W = OFF_W - 3;
    localparam int WAY_W  = way_w(WAYS);

    logic [BUS_W-1:0] data_mem  [WAYS][SETS*BEATS];
    logic [TAG_W-1:0] tag_mem   [WAYS][SETS];
    logic [SETS-1:0]  valid_q   [WAYS];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] adr_q;
    logic [WAY_W-1:0]  victim_q;
    logic              pending_q;
    logic [IDX_W-1:0]  flush_idx_q;
    logic [WAY_W-1:0]  rr_ptr_q [SETS];

    logic [IDX_W-1:0]  req_idx, fill_idx;
    logic [TAG_W-1:0]  req_tag, fill_tag;
    logic [BEAT_W-1:0] req_beat, fill_beat;
    logic              unused_addr_bits;

    assign req_idx   = i_addr[OFF_W +: IDX_W];
    assign req_tag   = i_addr[ADDR_W-1 -: TAG_W];
    assign req_beat  = i_addr[3 +: BEAT_W];
    assign fill_idx  = adr_q[OFF_W +: IDX_W];
    assign fill_tag  = adr_q[ADDR_W-1 -: TAG_W];
    assign fill_beat = adr_q[3 +: BEAT_W];
    assign unused_addr_bits = ^i_addr[1:0];

    logic [WAYS-1:0]  hit_vec, set_valid, victim_oh;
    logic [BUS_W-1:0] hit_beat;
    logic             hit_any;
    logic [WAY_W-1:0] victim_idx, rr_cur, rr_next;

    always_comb begin
        hit_vec   = '0;
        set_valid = '0;
        hit_beat  = '0;
        for (int w = 0; w < WAYS; w++) begin
            set_valid[w] = valid_q[w][req_idx];
            hit_vec[w]   = valid_q[w][req_idx] && (tag_mem[w][req_idx] == req_tag);
            if (hit_vec[w]) begin
                hit_beat = hit_beat | data_mem[w][{req_idx, req_beat}];
            end
        end
    end
    assign hit_any = |hit_vec;

    icache_victim_sel #(
        .WAYS (WAYS),
        .PTR_W(WAY_W)
    ) u_victim_sel (
        .valid    (set_valid),
        .ptr      (rr_ptr_q[req_idx]),
        .victim_oh(victim_oh)
    );

    always_comb begin
        victim_idx = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (victim_oh[w]) begin
                victim_idx = WAY_W'(w);
            end
        end
    end

    logic miss_start, beat_ok, last_beat, flush_req;

    assign miss_start = (state_q == ST_IDLE) && i_req && !hit_any && !i_invalidate;
    assign beat_ok    = (state_q == ST_REFILL) && wb.i_wb_ack && !wb.i_wb_rty && !wb.i_wb_stall;
    assign last_beat  = (fill_beat == BEAT_W'(BEATS - 1));
    assign flush_req  = pending_q || i_invalidate;
    assign rr_cur     = rr_ptr_q[fill_idx];
    assign rr_next    = (rr_cur == WAY_W'(WAYS - 1)) ? '0 : rr_cur + WAY_W'(1);

    always_comb begin
        state_d      = state_q;
        o_data_ready = 1'b0;
        o_data       = i_addr[2] ? hit_beat[63:32] : hit_beat[31:0];
        unique case (state_q)
            ST_IDLE: begin
                if (i_invalidate) begin
                    state_d = ST_FLUSH;
                end else if (i_req && !hit_any) begin
                    state_d = ST_REFILL;
                end else if (i_req) begin
                    o_data_ready = 1'b1;
                end
            end
            ST_REFILL: begin
                if (beat_ok && last_beat) begin
                    state_d = flush_req ? ST_FLUSH : ST_IDLE;
                end
`ifdef ICACHE_EARLY_FWD_EN
                if (i_req && beat_ok && (req_beat == fill_beat) &&
                    (i_addr[ADDR_W-1:OFF_W] == adr_q[ADDR_W-1:OFF_W])) begin
                    o_data_ready = 1'b1;
                    o_data       = i_addr[2] ? wb.i_wb_dat[63:32] : wb.i_wb_dat[31:0];
                end
`endif
            end
            ST_FLUSH: begin
                if (flush_idx_q == IDX_W'(SETS - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_FLUSH;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q     <= ST_FLUSH;
            pending_q   <= 1'b0;
            flush_idx_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                rr_ptr_q[s] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (state_q == ST_REFILL) begin
                if (i_invalidate) begin
                    pending_q <= 1'b1;
                end
                if (beat_ok && last_beat) begin
                    rr_ptr_q[fill_idx] <= rr_next;
                    if (flush_req) begin
                        pending_q <= 1'b0;
                    end
                end
            end
            if (state_q == ST_FLUSH) begin
                flush_idx_q <= flush_idx_q + IDX_W'(1);
            end
        end
    end

    // Storage updates are suppressed on a reset edge so an abandoned fill never becomes valid.
    always_ff @(posedge i_clk) begin
        if (miss_start) begin
            adr_q    <= {i_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
            victim_q <= victim_idx;
        end else if (beat_ok) begin
            adr_q <= adr_q + ADDR_W'(8);
        end
        if (i_reset_n) begin
            if (miss_start) begin
                valid_q[victim_idx][req_idx] <= 1'b0;
            end
            if (beat_ok) begin
                data_mem[victim_q][{fill_idx, fill_beat}] <= wb.i_wb_dat;
                if (last_beat) begin
                    tag_mem[victim_q][fill_idx] <= fill_tag;
                    if (!flush_req) begin
                        valid_q[victim_q][fill_idx] <= 1'b1;
                    end
                end
            end
            if (state_q == ST_FLUSH) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[w][flush_idx_q] <= 1'b0;
                end
            end
        end
    end

    assign wb.o_wb_adr  = adr_q;
    assign wb.o_wb_dat  = '0;
    assign wb.o_wb_we   = 1'b0;
    assign wb.o_wb_sel  = 8'hFF;
    assign wb.o_wb_cyc  = (state_q == ST_REFILL);
    assign wb.o_wb_stb  = (state_q == ST_REFILL);
    assign wb.o_wb_lock = (state_q == ST_REFILL);

    assign o_invalidating = i_invalidate || pending_q || (state_q == ST_FLUSH);

endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway (default parameters); follows ICACHE_EARLY_FWD_EN if defined.
module tb_icache_nway;

`ifdef ICACHE_EARLY_FWD_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk;
    logic        i_reset_n;
    logic        i_req;
    logic [63:0] i_addr;
    logic [31:0] o_data;
    logic        o_data_ready;
    logic        i_invalidate;
    logic        o_invalidating;
    int          total;
    int          passed;

    icache_if #(.ADDR_W(64)) wb ();

    icache_nway #(
        .ADDR_W    (64),
        .WAYS      (2),
        .SETS      (64),
        .LINE_BYTES(64)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (i_reset_n),
        .wb            (wb.master),
        .i_req         (i_req),
        .i_addr        (i_addr),
        .o_data        (o_data),
        .o_data_ready  (o_data_ready),
        .i_invalidate  (i_invalidate),
        .o_invalidating(o_invalidating)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] wrd(input logic [63:0] a);
        return 32'hC0DE_0000 ^ a[31:0];
    endfunction

    function automatic logic [63:0] beat_dat(input logic [63:0] a);
        return {wrd(a + 64'd4), wrd(a)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic hit(input logic [63:0] a, input logic [31:0] exp_word);
        i_req  = 1'b1;
        i_addr = a;
        #1;
        chk("hit_ready", {63'd0, o_data_ready}, 64'd1);
        chk("hit_data", {32'd0, o_data}, {32'd0, exp_word});
        i_req = 1'b0;
        step();
    endtask

    task automatic miss(input logic [63:0] a);
        i_req  = 1'b1;
        i_addr = a;
        #1;
        chk("miss_ready", {63'd0, o_data_ready}, 64'd0);
        i_req = 1'b0;
        step();
    endtask

    task automatic flush_wait(input string tag);
        int n;
        n = 0;
        while (o_invalidating === 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk(tag, 64'(n), 64'd64);
    endtask

    // Full line refill of the line holding ra; optional retry / invalidate / reset on one beat.
    task automatic fill(input logic [63:0] ra, input int rty_beat, input int inv_beat,
                        input int rst_beat);
        logic [63:0] base;
        logic        exp_fwd;
        base   = ra & ~64'h3F;
        i_req  = 1'b1;
        i_addr = ra;
        #1;
        chk("fill_miss", {63'd0, o_data_ready}, 64'd0);
        step();
        chk("fill_bus", {60'd0, wb.o_wb_cyc, wb.o_wb_stb, wb.o_wb_lock, wb.o_wb_we}, 64'hE);
        chk("fill_sel", {56'd0, wb.o_wb_sel}, 64'hFF);
        chk("fill_wdat", wb.o_wb_dat, 64'd0);
        for (int b = 0; b < 8; b++) begin
            chk("beat_adr", wb.o_wb_adr, base + 64'(8 * b));
            if (b == rty_beat) begin
                wb.i_wb_ack = 1'b1;
                wb.i_wb_rty = 1'b1;
                wb.i_wb_dat = 64'hDEAD_BEEF_DEAD_BEEF;
                #1;
                chk("rty_ready", {63'd0, o_data_ready}, 64'd0);
                step();
                chk("rty_adr", wb.o_wb_adr, base + 64'(8 * b));
                chk("rty_cyc", {63'd0, wb.o_wb_cyc}, 64'd1);
                wb.i_wb_rty = 1'b0;
            end
            if (b == rst_beat) begin
                wb.i_wb_ack = 1'b1;
                wb.i_wb_dat = beat_dat(base + 64'(8 * b));
                i_reset_n   = 1'b0;
                step();
                wb.i_wb_ack = 1'b0;
                chk("rst_bus", {61'd0, wb.o_wb_cyc, wb.o_wb_stb, wb.o_wb_lock}, 64'd0);
                chk("rst_inval", {63'd0, o_invalidating}, 64'd1);
                i_reset_n = 1'b1;
                i_req     = 1'b0;
                return;
            end
            wb.i_wb_ack  = 1'b1;
            wb.i_wb_dat  = beat_dat(base + 64'(8 * b));
            i_invalidate = (b == inv_beat);
            #1;
            if (inv_beat >= 0 && (b == inv_beat || b == inv_beat + 1))
                chk("inval_flag", {63'd0, o_invalidating}, 64'd1);
            exp_fwd = EARLY && (b == int'(ra[5:3]));
            chk("fwd_ready", {63'd0, o_data_ready}, {63'd0, exp_fwd});
            if (exp_fwd) chk("fwd_data", {32'd0, o_data}, {32'd0, wrd(ra)});
            step();
        end
        wb.i_wb_ack  = 1'b0;
        i_invalidate = 1'b0;
        chk("fill_end_cyc", {63'd0, wb.o_wb_cyc}, 64'd0);
    endtask

    initial begin
        total        = 0;
        passed       = 0;
        i_reset_n    = 1'b0;
        i_req        = 1'b0;
        i_addr       = '0;
        i_invalidate = 1'b0;
        wb.i_wb_dat  = '0;
        wb.i_wb_ack  = 1'b0;
        wb.i_wb_stall = 1'b0;
        wb.i_wb_rty  = 1'b0;

        // Reset and boot flush
        repeat (3) step();
        chk("reset_bus", {60'd0, wb.o_wb_cyc, wb.o_wb_stb, wb.o_wb_lock, wb.o_wb_we}, 64'd0);
        chk("reset_inval", {63'd0, o_invalidating}, 64'd1);
        i_reset_n = 1'b1;
        i_req     = 1'b1;
        i_addr    = 64'h1000;
        #1;
        chk("boot_no_ready", {63'd0, o_data_ready}, 64'd0);
        i_req = 1'b0;
        flush_wait("boot_flush_len");

        // First fill and hit
        fill(64'h1000, -1, -1, -1);
        hit(64'h1004, 32'hC0DE_1004);

        // Same-set eviction: third line replaces way 0
        fill(64'h3000, -1, -1, -1);
        fill(64'h5000, -1, -1, -1);
        hit(64'h3004, 32'hC0DE_3004);
        hit(64'h5008, 32'hC0DE_5008);
        miss(64'h1000);

        // Retry on beat 3; round-robin now evicts way 1 (0x3000)
        fill(64'h1000, 3, -1, -1);
        hit(64'h1018, 32'hC0DE_1018);
        hit(64'h101C, 32'hC0DE_101C);
        hit(64'h5000, 32'hC0DE_5000);
        miss(64'h3000);

        // Invalidate during refill
        fill(64'h2000, -1, 5, -1);
        flush_wait("refill_flush_len");
        miss(64'h1000);
        miss(64'h2000);

        // Reset mid-refill
        fill(64'h1000, -1, -1, 4);
        flush_wait("rst_flush_len");
        miss(64'h1000);

        // Critical-word request during refill
        fill(64'h1014, -1, -1, -1);
        hit(64'h1014, 32'hC0DE_1014);

        // Invalidate in IDLE blocks a hit
        i_req        = 1'b1;
        i_addr       = 64'h1014;
        i_invalidate = 1'b1;
        #1;
        chk("inval_idle_ready", {63'd0, o_data_ready}, 64'd0);
        chk("inval_idle_flag", {63'd0, o_invalidating}, 64'd1);
        step();
        i_invalidate = 1'b0;
        i_req        = 1'b0;
        flush_wait("idle_flush_len");
        miss(64'h1014);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/icache_nway.md
ICACHE_NWAY -- requirements
Module: icache_nway

Interface
REQ-001 SHALL provide parameter ADDR_W, default 64, fetch and bus address width.
REQ-002 SHALL provide parameter WAYS, default 2, associativity (power of two, 1..8).
REQ-003 SHALL provide parameter SETS, default 64, sets per way (power of two, >=2).
REQ-004 SHALL provide parameter LINE_BYTES, default 64, line size (power of two, 16..256); BEATS = LINE_BYTES/8.
REQ-005 SHALL have port i_clk  in  1  sole clock, all state on rising edge.
REQ-006 SHALL have port i_reset_n  in  1  synchronous, active-low reset.
REQ-007 SHALL have Wishbone master ports o_wb_adr out ADDR_W, i_wb_dat in 64, o_wb_dat out 64 (tied 0), o_wb_we out 1, o_wb_sel out 8, o_wb_stb out 1, i_wb_ack in 1, o_wb_cyc out 1, i_wb_stall in 1, i_wb_rty in 1, o_wb_lock out 1.
REQ-008 SHALL have port i_req  in  1  fetch request valid.
REQ-009 SHALL have port i_addr  in  ADDR_W  fetch byte address, bits [1:0] ignored.
REQ-010 SHALL have port o_data  out  32  fetched instruction word.
REQ-011 SHALL have port o_data_ready  out  1  o_data valid for i_addr this cycle.
REQ-012 SHALL have ports i_invalidate in 1 flush request; o_invalidating out 1 flush pending or active.

Function
REQ-013 Address split: offset = log2(LINE_BYTES) LSBs, index = next log2(SETS) bits, tag = remaining MSBs.
REQ-014 States: IDLE, REFILL, FLUSH; encoding in shared package.
REQ-015 IDLE hit (i_req, any way valid with matching tag, !i_invalidate): o_data_ready=1 combinationally, same cycle, o_data = selected 32-bit word.
REQ-016 IDLE miss: next edge latch address, choose victim way, clear victim valid, drive o_wb_adr = line base, o_wb_cyc=o_wb_stb=o_wb_lock=1, o_wb_we=0, o_wb_sel=8'hFF, enter REFILL.
REQ-017 Victim: lowest-index invalid way, else per-set round-robin pointer; pointer advances by one (mod WAYS) on each completed fill of that set.
REQ-018 REFILL beat accepted when i_wb_ack && !i_wb_rty && !i_wb_stall: write 64-bit data into victim line at beat offset, o_wb_adr += 8.
REQ-019 i_wb_rty with ack: beat discarded, o_wb_adr unchanged, bus signals held.
REQ-020 Last beat (offset field wraps to 0): write tag, set valid, deassert cyc/stb/lock next edge, return to IDLE; miss-to-hit latency = BEATS accepted beats + 1 cycle.
REQ-021 i_invalidate in IDLE: enter FLUSH next edge, o_data_ready=0 that cycle.
REQ-022 i_invalidate during REFILL: latch pending flag, complete refill without setting valid, then enter FLUSH.
REQ-023 FLUSH: clear valid of all ways of one set per cycle, index 0..SETS-1, then IDLE; exactly SETS cycles.
REQ-024 o_invalidating = i_invalidate || pending flag || state==FLUSH.
REQ-025 o_data_ready SHALL be 0 whenever state != IDLE, except REQ-030.

Reset
REQ-026 While i_reset_n=0 at an edge: o_wb_cyc=o_wb_stb=o_wb_lock=o_wb_we=0, pending flag=0, flush index=0, round-robin pointers=0, state=FLUSH.
REQ-027 After reset release the block SHALL complete a SETS-cycle FLUSH before any hit; o_invalidating=1 throughout.
REQ-028 Reset mid-REFILL SHALL abandon the bus cycle at that edge; partially filled line stays invalid.

Configuration
REQ-029 Macro ICACHE_EARLY_FWD_EN selects critical-word forwarding.
REQ-030 With macro: in REFILL, if i_req and i_addr line equals latched line and the accepted beat contains i_addr's word, o_data_ready=1 with o_data taken from i_wb_dat that cycle.
REQ-031 Without macro: o_data_ready only per REQ-015; no i_wb_dat-to-o_data path.

Structure
REQ-032 Package icache_pkg SHALL hold the state enum, bus width constant (64), and address-field width functions.
REQ-033 Sub-module icache_victim_sel SHALL implement REQ-017 (valid vector + pointer in, one-hot way out), purely combinational.
REQ-034 Data, tag, valid storage SHALL be per-way arrays inside icache_nway.

Verification
REQ-035 Reset, then req 0x1000 -> o_invalidating high 64 cycles, miss, 8 beats from 0x1000..0x1038, hit word at 0x1004 next IDLE cycle.
REQ-036 WAYS=2: fill 0x1000, 0x3000, 0x5000 (same set) -> third evicts way 0; 0x3000 still hits, 0x1000 misses.
REQ-037 Ack with rty on beat 3 -> o_wb_adr stays 0x1018, line data correct after retry.
REQ-038 i_invalidate on beat 5 -> refill completes, then 64-cycle flush, 0x1000 misses afterwards.
REQ-039 ICACHE_EARLY_FWD_EN set, req 0x1014 during refill -> o_data_ready on beat 2 with i_wb_dat[63:32]; unset -> ready only after refill.
REQ-040 i_reset_n low on beat 4 -> cyc/stb/lock 0 next edge, flush restarts, 0x1000 misses.
